// File: rtl/nbit_mwide_dual_read_register_file_if.sv
// Bus bundle for the dual-read register file: one write port, two read
// ports, a bulk-clear request and the status outputs. The datapath
// controller drives it through the master modport, and the register file
// receives it through the slave modport.
interface nbit_mwide_dual_read_register_file_if #(
    parameter int P_RegWidth = 3,
    parameter int P_BitWidth = 32
);
    logic [P_RegWidth-1:0] In_WriteAddress;
    logic [P_BitWidth-1:0] In_WriteData;
    logic                  In_Write;
    logic [P_RegWidth-1:0] In_ReadAddressA;
    logic                  In_ReadA;
    logic [P_RegWidth-1:0] In_ReadAddressB;
    logic                  In_ReadB;
    logic                  In_Clear;
    logic [P_BitWidth-1:0] Out_ReadDataA;
    logic                  Out_ValidA;
    logic [P_BitWidth-1:0] Out_ReadDataB;
    logic                  Out_ValidB;
    logic                  Out_Busy;
    logic                  Out_WriteDropped;

    modport master (
        output In_WriteAddress, In_WriteData, In_Write,
        output In_ReadAddressA, In_ReadA, In_ReadAddressB, In_ReadB,
        output In_Clear,
        input  Out_ReadDataA, Out_ValidA, Out_ReadDataB, Out_ValidB,
        input  Out_Busy, Out_WriteDropped
    );

    modport slave (
        input  In_WriteAddress, In_WriteData, In_Write,
        input  In_ReadAddressA, In_ReadA, In_ReadAddressB, In_ReadB,
        input  In_Clear,
        output Out_ReadDataA, Out_ValidA, Out_ReadDataB, Out_ValidB,
        output Out_Busy, Out_WriteDropped
    );
endinterface

// File: rtl/nbit_mwide_dual_read_register_file.sv
// Register file with one write port and two synchronous read ports. Reads
// are write-first: a read sees the value that the same edge commits. An
// optional register 0 is hardwired to zero. A CLEAR sweep can zero one
// register per cycle without a global reset.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | normal operation; writes commit
//  S_CLEAR | sweep zeroes reg[clr_cnt_q] each edge; writes are dropped
module nbit_mwide_dual_read_register_file #(
    parameter int P_RegWidth = 3,
    parameter int P_BitWidth = 32,
    parameter int P_ZeroReg  = 0
) (
    input  logic In_Clock_50MHz,
    input  logic In_Reset,
    nbit_mwide_dual_read_register_file_if.slave bus
);
    localparam int                    NumRegs  = 2 ** P_RegWidth;
    localparam logic [P_RegWidth-1:0] LastAddr = '1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                state_q;
    logic [P_RegWidth-1:0] clr_cnt_q;
    logic [P_BitWidth-1:0] mem_q [NumRegs];
    logic [P_BitWidth-1:0] rd_a_q, rd_b_q;
    logic                  valid_a_q, valid_b_q;
    logic                  busy_q, drop_q;

    logic                  clr_active;
    logic                  wr_commit;
    logic [P_BitWidth-1:0] rd_a_d, rd_b_d;
    logic                  drop_d;

    // Write qualification and write-first read data for both ports.
    // The write port and the sweep never commit in the same cycle, so the
    // two bypass terms cannot conflict.
    always_comb begin
        clr_active = (state_q == S_CLEAR);
        wr_commit  = bus.In_Write && !clr_active &&
                     !((P_ZeroReg != 0) && (bus.In_WriteAddress == '0));
        drop_d     = bus.In_Write && clr_active;

        rd_a_d = mem_q[bus.In_ReadAddressA];
        if ((P_ZeroReg != 0) && (bus.In_ReadAddressA == '0))
            rd_a_d = '0;
        else if (wr_commit && (bus.In_WriteAddress == bus.In_ReadAddressA))
            rd_a_d = bus.In_WriteData;
        else if (clr_active && (clr_cnt_q == bus.In_ReadAddressA))
            rd_a_d = '0;

        rd_b_d = mem_q[bus.In_ReadAddressB];
        if ((P_ZeroReg != 0) && (bus.In_ReadAddressB == '0))
            rd_b_d = '0;
        else if (wr_commit && (bus.In_WriteAddress == bus.In_ReadAddressB))
            rd_b_d = bus.In_WriteData;
        else if (clr_active && (clr_cnt_q == bus.In_ReadAddressB))
            rd_b_d = '0;
    end

    // Array, read registers, status pulses and clear-sweep FSM.
    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) begin
            for (int i = 0; i < NumRegs; i++)
                mem_q[i] <= '0;
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (wr_commit)
                mem_q[bus.In_WriteAddress] <= bus.In_WriteData;
            if (clr_active)
                mem_q[clr_cnt_q] <= '0;

            if (bus.In_ReadA)
                rd_a_q <= rd_a_d;
            if (bus.In_ReadB)
                rd_b_q <= rd_b_d;
            valid_a_q <= bus.In_ReadA;
            valid_b_q <= bus.In_ReadB;
            drop_q    <= drop_d;

            case (state_q)
                S_IDLE: begin
                    if (bus.In_Clear) begin
                        state_q   <= S_CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LastAddr) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out_ReadDataA    = rd_a_q;
    assign bus.Out_ValidA       = valid_a_q;
    assign bus.Out_ReadDataB    = rd_b_q;
    assign bus.Out_ValidB       = valid_b_q;
    assign bus.Out_Busy         = busy_q;
    assign bus.Out_WriteDropped = drop_q;
endmodule

// File: tb/tb_nbit_mwide_dual_read_register_file.sv
// Testbench for the dual-read register file. It drives the same stimulus
// into two instances: one without the zero register and one with it.
module tb_nbit_mwide_dual_read_register_file;
    localparam int RW = 3;
    localparam int BW = 32;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic [RW-1:0] wa = '0, ra = '0, rb = '0;
    logic [BW-1:0] wd = '0;
    logic          wr = 1'b0, rda = 1'b0, rdb = 1'b0, clr = 1'b0;

    nbit_mwide_dual_read_register_file_if #(.P_RegWidth(RW), .P_BitWidth(BW)) bus0 ();
    nbit_mwide_dual_read_register_file_if #(.P_RegWidth(RW), .P_BitWidth(BW)) bus1 ();

    assign bus0.In_WriteAddress = wa;  assign bus1.In_WriteAddress = wa;
    assign bus0.In_WriteData    = wd;  assign bus1.In_WriteData    = wd;
    assign bus0.In_Write        = wr;  assign bus1.In_Write        = wr;
    assign bus0.In_ReadAddressA = ra;  assign bus1.In_ReadAddressA = ra;
    assign bus0.In_ReadA        = rda; assign bus1.In_ReadA        = rda;
    assign bus0.In_ReadAddressB = rb;  assign bus1.In_ReadAddressB = rb;
    assign bus0.In_ReadB        = rdb; assign bus1.In_ReadB        = rdb;
    assign bus0.In_Clear        = clr; assign bus1.In_Clear        = clr;

    nbit_mwide_dual_read_register_file #(.P_RegWidth(RW), .P_BitWidth(BW), .P_ZeroReg(0)) dut0 (
        .In_Clock_50MHz(clk), .In_Reset(rst), .bus(bus0));
    nbit_mwide_dual_read_register_file #(.P_RegWidth(RW), .P_BitWidth(BW), .P_ZeroReg(1)) dut1 (
        .In_Clock_50MHz(clk), .In_Reset(rst), .bus(bus1));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    // Model: array contents after each edge; reads return post-edge
    // contents, which gives write-first bypass and clear bypass.
    logic [BW-1:0] m [2][NR];
    logic [BW-1:0] e_a [2], e_b [2];
    logic          e_va, e_vb, e_busy, e_drop;
    int            sweep;
    bit            started = 1'b0;

    task automatic model_edge();
        if (rst) begin
            for (int z = 0; z < 2; z++) begin
                for (int i = 0; i < NR; i++) m[z][i] = '0;
                e_a[z] = '0; e_b[z] = '0;
            end
            e_va = 0; e_vb = 0; e_busy = 0; e_drop = 0; sweep = 0;
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (!e_busy && wr && !(z == 1 && wa == 0)) m[z][wa] = wd;
                if (e_busy) m[z][sweep] = '0;
                if (rda) e_a[z] = (z == 1 && ra == 0) ? '0 : m[z][ra];
                if (rdb) e_b[z] = (z == 1 && rb == 0) ? '0 : m[z][rb];
            end
            e_va   = rda;
            e_vb   = rdb;
            e_drop = wr && e_busy;
            if (e_busy) begin
                sweep++;
                if (sweep == NR) begin e_busy = 0; sweep = 0; end
            end else if (clr) begin
                e_busy = 1; sweep = 0;
            end
        end
        started = 1'b1;
    endtask

    // Drive is done at posedge+2, so the model sees the same inputs as the DUT.
    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("dut0 dataA", bus0.Out_ReadDataA, e_a[0]);
            chk("dut0 dataB", bus0.Out_ReadDataB, e_b[0]);
            chk("dut1 dataA", bus1.Out_ReadDataA, e_a[1]);
            chk("dut1 dataB", bus1.Out_ReadDataB, e_b[1]);
            chk("dut0 validA", 32'(bus0.Out_ValidA), 32'(e_va));
            chk("dut0 validB", 32'(bus0.Out_ValidB), 32'(e_vb));
            chk("dut1 validA", 32'(bus1.Out_ValidA), 32'(e_va));
            chk("dut1 validB", 32'(bus1.Out_ValidB), 32'(e_vb));
            chk("dut0 busy", 32'(bus0.Out_Busy), 32'(e_busy));
            chk("dut1 busy", 32'(bus1.Out_Busy), 32'(e_busy));
            chk("dut0 drop", 32'(bus0.Out_WriteDropped), 32'(e_drop));
            chk("dut1 drop", 32'(bus1.Out_WriteDropped), 32'(e_drop));
        end
    end

    task automatic fill(input logic [BW-1:0] base);
        for (int i = 0; i < NR; i++) begin
            wr = 1; wa = RW'(i); wd = base + BW'(i);
            step();
        end
        wr = 0;
    endtask

    int bcount, dcount;

    initial begin
        // Reset.
        rst = 1; step(); step(); rst = 0;
        chk("reset busy", 32'(bus0.Out_Busy), 0);
        chk("reset dataA", bus0.Out_ReadDataA, 0);

        // 1: write then read on both ports.
        wr = 1; wa = 5; wd = 32'hDEADBEEF; step();
        wr = 0; rda = 1; ra = 5; rdb = 1; rb = 5; step();
        chk("t1 A", bus0.Out_ReadDataA, 32'hDEADBEEF);
        chk("t1 B", bus0.Out_ReadDataB, 32'hDEADBEEF);
        chk("t1 validA", 32'(bus0.Out_ValidA), 1);
        chk("t1 validB", 32'(bus0.Out_ValidB), 1);
        rda = 0; rdb = 0; step();
        chk("t1 validA drop", 32'(bus0.Out_ValidA), 0);
        chk("t1 A held", bus0.Out_ReadDataA, 32'hDEADBEEF);

        // 2: same-cycle bypass on A, reset value on B.
        wr = 1; wa = 3; wd = 32'h12345678; rda = 1; ra = 3; rdb = 1; rb = 2; step();
        wr = 0; rda = 0; rdb = 0;
        chk("t2 bypass A", bus0.Out_ReadDataA, 32'h12345678);
        chk("t2 B", bus0.Out_ReadDataB, 0);

        // 3: zero register.
        wr = 1; wa = 0; wd = 32'hFFFFFFFF; step();
        wr = 0; rda = 1; ra = 0; step();
        rda = 0;
        chk("t3 nozero A", bus0.Out_ReadDataA, 32'hFFFFFFFF);
        chk("t3 zero A", bus1.Out_ReadDataA, 0);
        chk("t3 zero drop", 32'(bus1.Out_WriteDropped), 0);

        // 4: fill 1..8, clear, with a dropped write and a read during the sweep.
        fill(1);
        clr = 1; step(); clr = 0;
        bcount = 0; dcount = 0;
        for (int k = 1; k <= 12; k++) begin
            if (bus0.Out_Busy) bcount++;
            if (bus0.Out_WriteDropped) dcount++;
            if (k == 2) begin wr = 1; wa = 7; wd = 32'h99; end
            if (k == 3) begin
                wr = 0; rda = 1; ra = 7;
                chk("t4 drop pulse", 32'(bus0.Out_WriteDropped), 1);
            end
            if (k == 4) begin
                rda = 0;
                chk("t4 read 7 mid clear", bus0.Out_ReadDataA, 8);
            end
            step();
        end
        chk("t4 busy cycles", 32'(bcount), 8);
        chk("t4 drop count", 32'(dcount), 1);
        for (int i = 0; i < NR; i++) begin
            rda = 1; ra = RW'(i); rdb = 1; rb = RW'(NR - 1 - i); step();
            chk("t4 cleared A", bus0.Out_ReadDataA, 0);
        end
        rda = 0; rdb = 0;

        // 5: reset in the middle of a clear.
        fill(32'h100);
        clr = 1; step(); clr = 0;
        step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("t5 busy", 32'(bus0.Out_Busy), 0);
        chk("t5 validA", 32'(bus0.Out_ValidA), 0);
        chk("t5 dataB", bus0.Out_ReadDataB, 0);
        wr = 1; wa = 1; wd = 32'hA5; step();
        wr = 0; rda = 1; ra = 1; rdb = 1; rb = 6; step();
        rda = 0; rdb = 0;
        chk("t5 readback", bus0.Out_ReadDataA, 32'hA5);
        chk("t5 reg6 reset", bus0.Out_ReadDataB, 0);

        // 6: a second clear request during the sweep is ignored.
        clr = 1; step(); clr = 0;
        bcount = 0;
        for (int k = 1; k <= 12; k++) begin
            if (bus0.Out_Busy) bcount++;
            if (k == 2) begin rdb = 1; rb = 1; end
            if (k == 3) begin
                clr = 1; rdb = 0;
                chk("t6 clear bypass", bus0.Out_ReadDataB, 0);
            end
            if (k == 4) clr = 0;
            step();
        end
        chk("t6 busy cycles", 32'(bcount), 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/nbit_mwide_dual_read_register_file.md
Name: nbit_mwide_dual_read_register_file

Overview:
Parametrised successor to the single-port N-bit M-wide register file. It has one write port and two independent read ports, A and B, which read synchronously. Reads that hit a same-cycle write see the new data. An optional hardwired zero register is available, and a sequenced bulk-clear FSM can zero the array without a global reset. It sits between the datapath control and the ALU operand buses in the lab-project processor.

Parameters:
P_RegWidth, 3, address width; the array holds 2**P_RegWidth registers.
P_BitWidth, 32, data width of each register.
P_ZeroReg, 0, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
In_Clock_50MHz  input  1  system clock; all state changes on its rising edge.
In_Reset  input  1  synchronous, active-high reset.
In_WriteAddress  input  P_RegWidth  write address.
In_WriteData  input  P_BitWidth  write data.
In_Write  input  1  write strobe.
In_ReadAddressA  input  P_RegWidth  read port A address.
In_ReadA  input  1  read port A strobe.
In_ReadAddressB  input  P_RegWidth  read port B address.
In_ReadB  input  1  read port B strobe.
In_Clear  input  1  single-cycle request to start a bulk clear.
Out_ReadDataA  output  P_BitWidth  registered read data for port A.
Out_ValidA  output  1  one-cycle qualifier for Out_ReadDataA.
Out_ReadDataB  output  P_BitWidth  registered read data for port B.
Out_ValidB  output  1  one-cycle qualifier for Out_ReadDataB.
Out_Busy  output  1  high while the clear sequence runs.
Out_WriteDropped  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset:
  - In_Reset is sampled at the clock edge and takes priority over every other input.
  - At that edge, all registers, Out_ReadDataA/B, Out_ValidA/B, Out_Busy and Out_WriteDropped go to 0.
  - The FSM goes to IDLE and the clear counter goes to 0.
  - Reset asserted mid-clear aborts the clear immediately.
- Write:
  - Occurs at the edge when In_Write=1 and the FSM is in IDLE: reg[In_WriteAddress] <= In_WriteData.
  - With P_ZeroReg=1 and In_WriteAddress=0, the write is silently discarded; no drop pulse.
  - In_Write=1 while the FSM is in CLEAR discards the write, and Out_WriteDropped=1 for the following cycle.
- Read:
  - If In_ReadX=1 at edge k, Out_ReadDataX is updated at edge k and Out_ValidX=1 for exactly the cycle after edge k. Latency is 1 clock.
  - If In_ReadX=0, Out_ValidX=0 and Out_ReadDataX holds its last value.
  - Both ports are fully independent; any address combination, including A=B, is legal.
- Read/write bypass:
  - Applies when the read address equals a write address that commits at the same edge.
  - The read returns In_WriteData (write-first).
  - A discarded write, whether to zero-reg or during CLEAR, is not bypassed.
- Zero register: with P_ZeroReg=1, reads of address 0 return 0 regardless of the array contents.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on an edge with In_Clear=1. A write in the same cycle still commits; it is then zeroed by the sweep.
  - In CLEAR, each edge zeroes reg[counter] and increments the counter.
  - After the edge that zeroes register 2**P_RegWidth-1, the counter wraps to 0 and the FSM returns to IDLE.
- Out_Busy:
  - Equals 1 exactly while the FSM is in CLEAR, which lasts 2**P_RegWidth cycles.
  - It asserts in the cycle after the In_Clear edge.
- In_Clear while in CLEAR is ignored; the sweep is not restarted.
- Reads during CLEAR:
  - Serviced normally and return the current contents.
  - A register zeroed at the same edge as the read returns 0 (bypass of the clear write).
- The counter is P_RegWidth bits wide and wraps naturally; no extra terminal logic beyond the last-address compare.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 5, then read A=5 and B=5 in the next cycle -> both ports show 0xDEADBEEF with ValidA=ValidB=1 for one cycle; the cycle after, Valid drops and data is held.
2. In one cycle, write 0x12345678 to addr 3 and read A=3, B=2 -> next cycle, A=0x12345678 (bypass) and B=0 (reset value).
3. P_ZeroReg=1: write 0xFFFFFFFF to addr 0, then read A=0 -> A=0, Out_WriteDropped stays 0; with P_ZeroReg=0 the same sequence returns 0xFFFFFFFF.
4. Fill all 8 registers with 1..8, pulse In_Clear -> Busy high for exactly 8 cycles.
   - A write to addr 7 at busy cycle 2 -> WriteDropped pulses once.
   - Read addr 7 at busy cycle 3 -> returns 8.
   - After Busy falls, all registers read 0.
5. Start a clear, then assert In_Reset at busy cycle 4 -> next cycle Busy=0, all outputs 0, all registers 0; a write to addr 1 with 0xA5 immediately after then commits and reads back 0xA5.
6. Pulse In_Clear again at busy cycle 3 -> total busy duration is still 8 cycles, not extended.
